cv32e40p_tmr_voter_monitor: RTL and testbench



---
 rtl/cv32e40p_tmr_voter_monitor.sv | 142 ++++++++++++++
 tb/tb_cv32e40p_tmr_voter_monitor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tmr_voter_monitor.sv
// rtl/cv32e40p_tmr_voter_monitor.sv - stateful multi-channel TMR voter with replica fault tracking
module cv32e40p_tmr_voter_monitor #(
    parameter int unsigned NBIT    = 32,
    parameter int unsigned NCH     = 3,
    parameter int unsigned ERR_THR = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic                  clear_i,
    input  logic [NCH*NBIT-1:0]   data1_i,
    input  logic [NCH*NBIT-1:0]   data2_i,
    input  logic [NCH*NBIT-1:0]   data3_i,
    output logic [NCH*NBIT-1:0]   dataout_o,
    output logic [NCH-1:0]        mismatch_o,
    output logic [2:0]            fault_replica_o,
    output logic [3*CNT_W-1:0]    err_cnt_o,
    output logic                  degraded_o,
    output logic                  uncorrectable_o
);

    localparam int unsigned W = NCH * NBIT;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(ERR_THR);

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DEGRADED = 2'd1,
        FAILED   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [3];
    logic [CNT_W-1:0]   cnt_d [3];
    logic [2:0]         fault_q, fault_d;

    logic [W-1:0]       maj_w;
    logic [W-1:0]       h0_w;
    logic [W-1:0]       h1_w;
    logic [2:0]         dis;
    logic [NCH-1:0]     vote_mm;
    logic [NCH-1:0]     pair_mm;
    logic [2:0]         new_f;

    // Majority vote, per-replica disagreement and the healthy-pair comparison
    always_comb begin
        maj_w  = (data1_i & data2_i) | (data1_i & data3_i) | (data2_i & data3_i);
        dis[0] = (data1_i != maj_w);
        dis[1] = (data2_i != maj_w);
        dis[2] = (data3_i != maj_w);
        // Exactly one replica is faulty in DEGRADED; h0 < h1 are the remaining two
        h0_w   = fault_q[0] ? data2_i : data1_i;
        h1_w   = fault_q[2] ? data2_i : data3_i;
        vote_mm = '0;
        pair_mm = '0;
        for (int c = 0; c < NCH; c++) begin
            vote_mm[c] = (data1_i[c*NBIT +: NBIT] != maj_w[c*NBIT +: NBIT]) ||
                         (data2_i[c*NBIT +: NBIT] != maj_w[c*NBIT +: NBIT]) ||
                         (data3_i[c*NBIT +: NBIT] != maj_w[c*NBIT +: NBIT]);
            pair_mm[c] = (h0_w[c*NBIT +: NBIT] != h1_w[c*NBIT +: NBIT]);
        end
    end

    // Output selection: vote in NORMAL/FAILED, first healthy replica in DEGRADED
    always_comb begin
        dataout_o  = maj_w;
        mismatch_o = vote_mm;
        if (state_q == DEGRADED) begin
            dataout_o  = h0_w;
            mismatch_o = pair_mm;
        end
        err_cnt_o = '0;
        for (int k = 0; k < 3; k++) begin
            err_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
        end
        fault_replica_o = fault_q;
        degraded_o      = (state_q == DEGRADED);
        uncorrectable_o = (state_q == FAILED);
    end

    // Next-state logic: counters and fault latches move only on valid cycles in NORMAL
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        new_f   = '0;
        if (valid_i) begin
            unique case (state_q)
                NORMAL: begin
                    for (int k = 0; k < 3; k++) begin
                        if (!fault_q[k]) begin
                            if (dis[k]) begin
                                cnt_d[k] = (cnt_q[k] == CNT_MAX) ? CNT_MAX : cnt_q[k] + CNT_W'(1);
                            end else begin
                                cnt_d[k] = '0;
                            end
                            new_f[k] = (cnt_d[k] >= THR);
                        end
                    end
                    fault_d = fault_q | new_f;
                    if (new_f != 3'b000) begin
                        // More than one bit set means two replicas died together
                        state_d = ((new_f & (new_f - 3'd1)) != 3'b000) ? FAILED : DEGRADED;
                    end
                end
                DEGRADED: begin
                    if (pair_mm != '0) begin
                        state_d = FAILED;
                    end
                end
                default: begin
                end
            endcase
        end
        if (clear_i) begin
            state_d = NORMAL;
            fault_d = '0;
            for (int k = 0; k < 3; k++) begin
                cnt_d[k] = '0;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            fault_q <= '0;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_tmr_voter_monitor.sv
// tb/tb_cv32e40p_tmr_voter_monitor.sv - scoreboard bench for the TMR voter monitor
module tb_cv32e40p_tmr_voter_monitor;

    localparam int NBIT = 32;
    localparam int NCH  = 3;
    localparam int THR  = 3;
    localparam int CW   = 4;
    localparam int W    = NBIT * NCH;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           valid_i = 1'b0;
    logic           clear_i = 1'b0;
    logic [W-1:0]   data1_i = '0;
    logic [W-1:0]   data2_i = '0;
    logic [W-1:0]   data3_i = '0;
    logic [W-1:0]   dataout_o;
    logic [NCH-1:0] mismatch_o;
    logic [2:0]     fault_replica_o;
    logic [3*CW-1:0] err_cnt_o;
    logic           degraded_o;
    logic           uncorrectable_o;

    cv32e40p_tmr_voter_monitor #(
        .NBIT(NBIT), .NCH(NCH), .ERR_THR(THR), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .clear_i(clear_i),
        .data1_i(data1_i), .data2_i(data2_i), .data3_i(data3_i),
        .dataout_o(dataout_o), .mismatch_o(mismatch_o),
        .fault_replica_o(fault_replica_o), .err_cnt_o(err_cnt_o),
        .degraded_o(degraded_o), .uncorrectable_o(uncorrectable_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic [W-1:0]    dout;
        logic [NCH-1:0]  mm;
        logic [2:0]      fault;
        logic [3*CW-1:0] cnt;
        logic            deg;
        logic            unc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state: 0 NORMAL, 1 DEGRADED, 2 FAILED
    int   m_state = 0;
    int   m_cnt [3] = '{0, 0, 0};
    bit   m_fault [3] = '{0, 0, 0};

    localparam logic [W-1:0] CLEAN = {NCH{32'hDEADBEEF}};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] rep(input int k);
        if (k == 0) return data1_i;
        if (k == 1) return data2_i;
        return data3_i;
    endfunction

    // Build the expected record for the current inputs and current model state
    function automatic exp_t predict(input string tag);
        exp_t e;
        logic [W-1:0] m, a, b;
        int h [$];
        m = '0;
        for (int i = 0; i < W; i++) begin
            int ones;
            ones = int'(data1_i[i]) + int'(data2_i[i]) + int'(data3_i[i]);
            m[i] = (ones >= 2);
        end
        e.tag = tag;
        e.dout = m;
        e.mm = '0;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 3; k++) begin
                a = rep(k);
                if (a[c*NBIT +: NBIT] != m[c*NBIT +: NBIT]) e.mm[c] = 1'b1;
            end
        end
        if (m_state == 1) begin
            for (int k = 0; k < 3; k++) if (!m_fault[k]) h.push_back(k);
            a = rep(h[0]);
            b = rep(h[1]);
            e.dout = a;
            for (int c = 0; c < NCH; c++) e.mm[c] = (a[c*NBIT +: NBIT] != b[c*NBIT +: NBIT]);
        end
        for (int k = 0; k < 3; k++) begin
            e.fault[k] = m_fault[k];
            e.cnt[k*CW +: CW] = CW'(m_cnt[k]);
        end
        e.deg = (m_state == 1);
        e.unc = (m_state == 2);
        return e;
    endfunction

    // Advance the model across one clock edge
    task automatic model_edge(input logic [NCH-1:0] mm_now);
        int nf;
        if (rst || clear_i) begin
            m_state = 0;
            for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_fault[k] = 0; end
        end else if (valid_i) begin
            if (m_state == 0) begin
                nf = 0;
                for (int k = 0; k < 3; k++) begin
                    if (!m_fault[k]) begin
                        logic [W-1:0] r;
                        logic [W-1:0] mv;
                        r  = rep(k);
                        mv = (data1_i & data2_i) | (data2_i & data3_i) | (data1_i & data3_i);
                        if (r != mv) m_cnt[k] = (m_cnt[k] < (1 << CW) - 1) ? m_cnt[k] + 1 : m_cnt[k];
                        else m_cnt[k] = 0;
                        if (m_cnt[k] >= THR) begin m_fault[k] = 1; nf++; end
                    end
                end
                if (nf == 1) m_state = 1;
                else if (nf >= 2) m_state = 2;
            end else if (m_state == 1) begin
                if (mm_now != '0) m_state = 2;
            end
        end
    endtask

    // One cycle: drive, push expectation, sample mid-cycle, pop and compare, clock
    task automatic step(input string tag, input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input logic [W-1:0] d3, input logic v, input logic clr, input logic r);
        exp_t e;
        data1_i = d1; data2_i = d2; data3_i = d3;
        valid_i = v; clear_i = clr; rst = r;
        exp_q.push_back(predict(tag));
        #2;
        e = exp_q.pop_front();
        check({e.tag, ".dout"}, dataout_o, e.dout);
        check({e.tag, ".mm"}, mismatch_o, e.mm);
        check({e.tag, ".fault"}, fault_replica_o, e.fault);
        check({e.tag, ".cnt"}, err_cnt_o, e.cnt);
        check({e.tag, ".deg"}, degraded_o, e.deg);
        check({e.tag, ".unc"}, uncorrectable_o, e.unc);
        model_edge(e.mm);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] bad3, bad1, bad2, d1_one, d2_zero;

    initial begin
        bad3    = CLEAN ^ (96'h1 << 32);          // replica 2, channel 1 -> 0xDEADBEEE
        bad1    = CLEAN ^ (96'h1 << 4);
        bad2    = CLEAN ^ (96'h1 << 70);
        d1_one  = {CLEAN[W-1:32], 32'h1};
        d2_zero = {CLEAN[W-1:32], 32'h0};

        @(posedge clk); #1;
        step("rst0", CLEAN, CLEAN, CLEAN, 1, 0, 1);
        step("rst1", bad3, bad3, CLEAN, 1, 0, 1);
        check("reset_fault", fault_replica_o, 3'b000);
        check("reset_cnt", err_cnt_o, 12'h000);

        for (int i = 0; i < 3; i++) step("clean", CLEAN, CLEAN, CLEAN, 1, 0, 0);
        check("clean_dout", dataout_o, CLEAN);

        step("run2a", CLEAN, CLEAN, bad3, 1, 0, 0);
        check("run2a_cnt2", err_cnt_o[8 +: 4], 4'd1);
        step("run2b", CLEAN, CLEAN, bad3, 1, 0, 0);
        check("run2b_cnt2", err_cnt_o[8 +: 4], 4'd2);
        step("run2c", CLEAN, CLEAN, CLEAN, 1, 0, 0);
        check("run2c_cnt2", err_cnt_o[8 +: 4], 4'd0);

        step("gap_a", CLEAN, CLEAN, bad3, 1, 0, 0);
        step("gap_b", CLEAN, CLEAN, bad3, 1, 0, 0);
        step("gap_c", CLEAN, CLEAN, bad3, 0, 0, 0);
        check("gap_nofault", fault_replica_o, 3'b000);
        step("gap_d", CLEAN, CLEAN, bad3, 1, 0, 0);
        check("deg_fault", fault_replica_o, 3'b100);
        check("deg_flag", degraded_o, 1'b1);
        step("deg_follow", CLEAN, CLEAN, ~CLEAN, 1, 0, 0);

        step("deg_diff", d1_one, d2_zero, CLEAN, 1, 0, 0);
        check("failed_unc", uncorrectable_o, 1'b1);
        check("failed_deg", degraded_o, 1'b0);
        step("failed_hold", CLEAN, CLEAN, bad3, 1, 0, 0);

        step("clr", CLEAN, CLEAN, CLEAN, 1, 1, 0);
        for (int i = 0; i < 3; i++) step("dual", bad1, bad2, CLEAN, 1, 0, 0);
        check("dual_fault", fault_replica_o, 3'b011);
        check("dual_unc", uncorrectable_o, 1'b1);

        step("clr2", CLEAN, CLEAN, CLEAN, 1, 1, 0);
        step("thr_a", CLEAN, CLEAN, bad3, 1, 0, 0);
        step("thr_b", CLEAN, CLEAN, bad3, 1, 0, 0);
        step("thr_clr", CLEAN, CLEAN, bad3, 1, 1, 0);
        check("clr_fault", fault_replica_o, 3'b000);
        check("clr_cnt", err_cnt_o, 12'h000);
        for (int i = 0; i < 3; i++) step("redeg", CLEAN, CLEAN, bad3, 1, 0, 0);
        check("redeg_flag", degraded_o, 1'b1);
        step("rst_deg", CLEAN, CLEAN, bad3, 1, 0, 1);
        check("rst_deg_flag", degraded_o, 1'b0);
        check("rst_deg_fault", fault_replica_o, 3'b000);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] r1, r2, r3;
            int pick;
            r1 = CLEAN; r2 = CLEAN; r3 = CLEAN;
            pick = $urandom_range(0, 5);
            if (pick == 0) r1 = CLEAN ^ (96'h1 << $urandom_range(0, W - 1));
            if (pick == 1) r2 = CLEAN ^ (96'h1 << $urandom_range(0, W - 1));
            if (pick == 2) r3 = CLEAN ^ (96'h1 << $urandom_range(0, W - 1));
            step("rand", r1, r2, r3, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
